// File: rtl/xram_arb.sv
// xram_arb: round-robin arbiter giving NREQ requesters shared access to one XRAM port.
// A grant lasts until xram_ack, until the owner drops its strobe, or until the wait timeout.
// Optional feature macro: XRAM_ARB_LOCK_EN. When it is defined, an owner holding req_lock
// keeps the grant across back-to-back accesses.
//
// state   | meaning
// S_IDLE  | no owner; the next owner is picked from the strobes, searching after r_last
// S_GRANT | r_g owns the XRAM port; the wait counter runs until ack, strobe drop or timeout
module xram_arb #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_stb,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [16*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  input  logic [NREQ-1:0]      req_lock,
  output logic [NREQ-1:0]      req_ack,
  output logic [7:0]           req_rdata,
  output logic [15:0]          xram_addr,
  output logic [7:0]           xram_data_out,
  output logic                 xram_stb,
  output logic                 xram_wr,
  input  logic [7:0]           xram_data_in,
  input  logic                 xram_ack,
  output logic [NREQ-1:0]      arb_grant,
  output logic                 arb_busy,
  output logic                 arb_err,
  output logic [7:0]           arb_err_cnt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IW-1:0]  r_g;
  logic [IW-1:0]  r_last;
  logic [7:0]     r_wait;
  logic           r_err;
  logic [7:0]     r_err_cnt;

  logic [IW-1:0]  w_sel;
  logic           w_any;
  logic           w_g_stb;
  logic           w_g_wr;
  logic           w_g_lock;
  logic [15:0]    w_g_addr;
  logic [7:0]     w_g_wdata;
  logic           w_wait_end;
  logic           w_hold;
  logic           w_timeout;

  // Mux out the signals of the current owner.
  always_comb begin
    w_g_stb   = 1'b0;
    w_g_wr    = 1'b0;
    w_g_lock  = 1'b0;
    w_g_addr  = '0;
    w_g_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_g == IW'(i)) begin
        w_g_stb   = req_stb[i];
        w_g_wr    = req_wr[i];
        w_g_lock  = req_lock[i];
        w_g_addr  = req_addr[16*i +: 16];
        w_g_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // Round-robin pick: the first strobe found, searching upward from r_last+1 and wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_sel = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_any && req_stb[idx]) begin
        w_any = 1'b1;
        w_sel = IW'(idx);
      end
    end
  end

`ifdef XRAM_ARB_LOCK_EN
  assign w_hold = (r_state == S_GRANT) & xram_ack & w_g_lock & w_g_stb;
`else
  assign w_hold = 1'b0 & w_g_lock;
`endif

  // The wait counter starts at 0 on the first grant cycle, so it equals TIMEOUT-1
  // on grant cycle number TIMEOUT.
  assign w_wait_end = (r_wait == 8'(TIMEOUT - 1));
  // An ack in the last allowed cycle wins over the timeout. A dropped strobe also
  // ends the grant without raising an error.
  assign w_timeout  = (r_state == S_GRANT) & ~xram_ack & w_g_stb & w_wait_end;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        if (xram_ack)        w_state_nxt = w_hold ? S_GRANT : S_IDLE;
        else if (!w_g_stb)   w_state_nxt = S_IDLE;
        else if (w_wait_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Grant index, round-robin pointer, wait counter and error bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g       <= '0;
      r_last    <= IW'(NREQ - 1);
      r_wait    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_timeout;
      if (w_timeout && (r_err_cnt != 8'hff)) r_err_cnt <= r_err_cnt + 8'd1;
      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_g    <= w_sel;
          r_last <= w_sel;
          r_wait <= '0;
        end
      end else begin
        if (w_hold)         r_wait <= '0;
        else if (!xram_ack) r_wait <= r_wait + 8'd1;
      end
    end
  end

  // One-hot grant vector, valid only while an owner exists.
  always_comb begin
    arb_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((r_state == S_GRANT) && (r_g == IW'(i))) arb_grant[i] = 1'b1;
    end
  end

  assign arb_busy      = (r_state == S_GRANT);
  assign req_ack       = arb_grant & {NREQ{xram_ack}};
  assign req_rdata     = xram_data_in;
  assign xram_stb      = arb_busy & w_g_stb;
  assign xram_wr       = arb_busy & w_g_wr;
  assign xram_addr     = arb_busy ? w_g_addr  : 16'h0000;
  assign xram_data_out = arb_busy ? w_g_wdata : 8'h00;
  assign arb_err       = r_err;
  assign arb_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_xram_arb.sv
// tb_xram_arb: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter (default NREQ=3, TIMEOUT=64).
module tb_xram_arb;

  localparam int N  = 3;
  localparam int TO = 64;
`ifdef XRAM_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_stb = '0;
  logic [N-1:0]  req_wr = '0;
  logic [16*N-1:0] req_addr = '0;
  logic [8*N-1:0]  req_wdata = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N-1:0]  req_ack;
  logic [7:0]    req_rdata;
  logic [15:0]   xram_addr;
  logic [7:0]    xram_data_out;
  logic          xram_stb;
  logic          xram_wr;
  logic [7:0]    xram_data_in = '0;
  logic          xram_ack = 1'b0;
  logic [N-1:0]  arb_grant;
  logic          arb_busy;
  logic          arb_err;
  logic [7:0]    arb_err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  xram_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock), .req_ack(req_ack), .req_rdata(req_rdata),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_stb(xram_stb),
    .xram_wr(xram_wr), .xram_data_in(xram_data_in), .xram_ack(xram_ack),
    .arb_grant(arb_grant), .arb_busy(arb_busy), .arb_err(arb_err), .arb_err_cnt(arb_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    req_stb = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({arb_grant, arb_busy, xram_stb, xram_wr, req_ack, arb_err, arb_err_cnt} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b busy=%b stb=%b wr=%b ack=%b err=%b cnt=%0d, want all zero",
               arb_grant, arb_busy, xram_stb, xram_wr, req_ack, arb_err, arb_err_cnt);
    end
    @(negedge clk);
    req_stb = '0;
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    @(negedge clk);
    req_stb = 3'b111;
    #1;
    n_chk++;
    if (xram_stb !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle_stb: got %b want 0", xram_stb);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 3'(1 << (i % 3));
      @(negedge clk); #1;
      n_chk++;
      if ({arb_grant, xram_stb} !== {exp, 1'b1}) begin
        n_fail++; $display("FAIL rr_grant%0d: grant=%b stb=%b want grant=%b stb=1", i, arb_grant, xram_stb, exp);
      end
      @(negedge clk); xram_ack = 1'b1; #1;
      n_chk++;
      if (req_ack !== exp) begin
        n_fail++; $display("FAIL rr_ack%0d: got %b want %b", i, req_ack, exp);
      end
      @(negedge clk); xram_ack = 1'b0;
      if (i == 3) req_stb = '0;
      #1;
      n_chk++;
      if ({arb_busy, req_ack} !== 4'b0) begin
        n_fail++; $display("FAIL rr_gap%0d: busy=%b ack=%b want 0/000", i, arb_busy, req_ack);
      end
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    req_stb = 3'b010; req_wr = 3'b000; req_addr[31:16] = 16'hf9f2;
    #1;
    @(negedge clk); #1;
    n_chk++;
    if ({xram_addr, xram_wr, arb_grant} !== {16'hf9f2, 1'b0, 3'b010}) begin
      n_fail++; $display("FAIL read_port: addr=%h wr=%b grant=%b want f9f2/0/010", xram_addr, xram_wr, arb_grant);
    end
    @(negedge clk); xram_ack = 1'b1; xram_data_in = 8'h5a; #1;
    n_chk++;
    if ({req_rdata, req_ack} !== {8'h5a, 3'b010}) begin
      n_fail++; $display("FAIL read_ack: rdata=%h ack=%b want 5a/010", req_rdata, req_ack);
    end
    @(negedge clk); xram_ack = 1'b0; req_stb = '0; #1;
    n_chk++;
    if ({req_ack, arb_busy} !== 4'b0) begin
      n_fail++; $display("FAIL read_ack_once: ack=%b busy=%b want 000/0", req_ack, arb_busy);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); req_stb = 3'b001; #1;
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    #1;
    n_chk++;
    if ({arb_busy, arb_err, arb_grant} !== {1'b1, 1'b0, 3'b001}) begin
      n_fail++; $display("FAIL to_last_cycle: busy=%b err=%b grant=%b want 1/0/001", arb_busy, arb_err, arb_grant);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({arb_busy, arb_err, arb_err_cnt} !== {1'b0, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL to_abort: busy=%b err=%b cnt=%0d want 0/1/1", arb_busy, arb_err, arb_err_cnt);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({arb_busy, arb_err} !== 2'b10) begin
      n_fail++; $display("FAIL to_err_pulse: busy=%b err=%b want 1/0", arb_busy, arb_err);
    end
    repeat (TO - 1) @(negedge clk);
    xram_ack = 1'b1; #1;
    n_chk++;
    if ({arb_busy, req_ack} !== 4'b1001) begin
      n_fail++; $display("FAIL to_ack_wins: busy=%b ack=%b want 1/001", arb_busy, req_ack);
    end
    @(negedge clk); xram_ack = 1'b0; req_stb = '0; #1;
    n_chk++;
    if ({arb_busy, arb_err, arb_err_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL to_no_err: busy=%b err=%b cnt=%0d want 0/0/1", arb_busy, arb_err, arb_err_cnt);
    end
  endtask

  task automatic test_abort();
    @(negedge clk); req_stb = 3'b100; #1;
    @(negedge clk); #1;
    n_chk++;
    if ({arb_grant, xram_stb} !== 4'b1001) begin
      n_fail++; $display("FAIL abort_grant: grant=%b stb=%b want 100/1", arb_grant, xram_stb);
    end
    @(negedge clk); req_stb = 3'b000; #1;
    n_chk++;
    if ({xram_stb, req_ack, arb_busy} !== 5'b00001) begin
      n_fail++; $display("FAIL abort_drop: stb=%b ack=%b busy=%b want 0/000/1", xram_stb, req_ack, arb_busy);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({arb_busy, req_ack, arb_err_cnt} !== {1'b0, 3'b000, 8'd1}) begin
      n_fail++; $display("FAIL abort_idle: busy=%b ack=%b cnt=%0d want 0/000/1", arb_busy, req_ack, arb_err_cnt);
    end
  endtask

  task automatic test_lock();
    @(negedge clk); req_stb = 3'b011; req_lock = 3'b001; #1;
    @(negedge clk);
    if (LOCK) begin
      for (int k = 1; k <= 4; k++) begin
        xram_ack = 1'b1;
        req_lock = (k < 4) ? 3'b001 : 3'b000;
        #1;
        n_chk++;
        if ({arb_grant, arb_busy, req_ack} !== 7'b001_1_001) begin
          n_fail++; $display("FAIL lock_b2b%0d: grant=%b busy=%b ack=%b want 001/1/001", k, arb_grant, arb_busy, req_ack);
        end
        @(negedge clk);
      end
      xram_ack = 1'b0; #1;
      n_chk++;
      if (arb_busy !== 1'b0) begin
        n_fail++; $display("FAIL lock_release: busy=%b want 0", arb_busy);
      end
      @(negedge clk); #1;
      n_chk++;
      if (arb_grant !== 3'b010) begin
        n_fail++; $display("FAIL lock_next: grant=%b want 010", arb_grant);
      end
      xram_ack = 1'b1;
    end else begin
      xram_ack = 1'b1; #1;
      n_chk++;
      if (req_ack !== 3'b001) begin
        n_fail++; $display("FAIL nolock_ack0: ack=%b want 001", req_ack);
      end
      @(negedge clk); xram_ack = 1'b0; #1;
      n_chk++;
      if (arb_busy !== 1'b0) begin
        n_fail++; $display("FAIL nolock_gap0: busy=%b want 0", arb_busy);
      end
      @(negedge clk); #1;
      n_chk++;
      if (arb_grant !== 3'b010) begin
        n_fail++; $display("FAIL nolock_grant1: grant=%b want 010", arb_grant);
      end
      xram_ack = 1'b1; #1;
      @(negedge clk); xram_ack = 1'b0; #1;
      @(negedge clk); #1;
      n_chk++;
      if (arb_grant !== 3'b001) begin
        n_fail++; $display("FAIL nolock_grant0: grant=%b want 001", arb_grant);
      end
      xram_ack = 1'b1;
    end
    @(negedge clk); xram_ack = 1'b0; req_stb = '0; req_lock = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); req_stb = 3'b111; #1;
    @(negedge clk); #1;
    n_chk++;
    if (arb_busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_granted: busy=%b want 1", arb_busy);
    end
    #1; xram_ack = 1'b1; rst = 1'b0; #1;
    n_chk++;
    if ({arb_busy, arb_grant, xram_stb, req_ack, arb_err_cnt} !== 16'h0) begin
      n_fail++; $display("FAIL rmid_abort: busy=%b grant=%b stb=%b ack=%b cnt=%0d want all zero",
                         arb_busy, arb_grant, xram_stb, req_ack, arb_err_cnt);
    end
    @(negedge clk); xram_ack = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (arb_grant !== 3'b001) begin
      n_fail++; $display("FAIL rmid_first: grant=%b want 001", arb_grant);
    end
    req_stb = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int m_owner, m_last, m_age, m_cnt, idx;
    bit m_err, quiet;
    logic [32:0] e_bus;
    logic [2:0]  e_grant, e_ack;
    @(negedge clk); rst = 1'b0; req_stb = '0; #1;
    @(negedge clk); rst = 1'b1;
    m_owner = -1; m_last = N - 1; m_age = 0; m_cnt = 0; m_err = 1'b0;
    for (int c = 0; c < 2100; c++) begin
      @(negedge clk);
      quiet = (c % 700) >= 450;
      for (int i = 0; i < N; i++) begin
        req_stb[i] = quiet ? 1'b1 : ($urandom_range(3, 0) != 0);
        req_addr[16*i +: 16] = 16'($urandom);
        req_wdata[8*i +: 8]  = 8'($urandom);
      end
      req_wr   = 3'($urandom);
      req_lock = 3'($urandom);
      xram_ack = quiet ? ($urandom_range(99, 0) == 0) : ($urandom_range(2, 0) == 0);
      xram_data_in = 8'($urandom);
      #1;
      e_grant = '0; e_ack = '0;
      if (m_owner >= 0) begin
        e_grant = 3'(1 << m_owner);
        if (xram_ack) e_ack = e_grant;
        e_bus = {e_grant, 1'b1, req_stb[m_owner], req_wr[m_owner],
                 req_addr[16*m_owner +: 16], req_wdata[8*m_owner +: 8], e_ack};
      end else begin
        e_bus = '0;
      end
      n_chk++;
      if ({arb_grant, arb_busy, xram_stb, xram_wr, xram_addr, xram_data_out, req_ack} !== e_bus) begin
        n_fail++;
        $display("FAIL rand_port c=%0d: got %h want %h", c,
                 {arb_grant, arb_busy, xram_stb, xram_wr, xram_addr, xram_data_out, req_ack}, e_bus);
      end
      n_chk++;
      if (req_rdata !== xram_data_in) begin
        n_fail++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, req_rdata, xram_data_in);
      end
      n_chk++;
      if ({arb_err, arb_err_cnt} !== {m_err, 8'(m_cnt)}) begin
        n_fail++; $display("FAIL rand_err c=%0d: err=%b cnt=%0d want %b/%0d", c, arb_err, arb_err_cnt, m_err, m_cnt);
      end
      @(posedge clk);
      m_err = 1'b0;
      if (m_owner < 0) begin
        if (req_stb != '0) begin
          for (int k = N; k >= 1; k--) begin
            idx = (m_last + k) % N;
            if (req_stb[idx]) m_owner = idx;
          end
          m_last = m_owner;
          m_age  = 1;
        end
      end else if (xram_ack) begin
        if (LOCK && req_lock[m_owner] && req_stb[m_owner]) m_age = 1;
        else m_owner = -1;
      end else if (!req_stb[m_owner]) begin
        m_owner = -1;
      end else if (m_age == TO) begin
        m_owner = -1;
        m_err   = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_age++;
      end
    end
    @(negedge clk); req_stb = '0; xram_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_timeout();
    test_abort();
    test_lock();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xram_arb.md
XRAM_ARB -- requirements
Module: xram_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of requesters, legal range 2..4.
REQ-002 The block SHALL have parameter TIMEOUT, default 64: maximum cycles a grant waits for xram_ack, legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_stb  input  NREQ  per-requester access strobe.
REQ-006 req_wr  input  NREQ  per-requester write enable (1=write).
REQ-007 req_addr  input  16*NREQ  per-requester address; requester i at bits [16i+15:16i].
REQ-008 req_wdata  input  8*NREQ  per-requester write data; requester i at bits [8i+7:8i].
REQ-009 req_lock  input  NREQ  per-requester hold-grant request.
REQ-010 req_ack  output  NREQ  per-requester access-complete pulse.
REQ-011 req_rdata  output  8  read data, broadcast to all requesters.
REQ-012 xram_addr / xram_data_out / xram_stb / xram_wr  output  16/8/1/1  XRAM port.
REQ-013 xram_data_in / xram_ack  input  8/1  XRAM read data and acknowledge.
REQ-014 arb_grant  output  NREQ  one-hot current grant; all zero when idle.
REQ-015 arb_busy  output  1  high in GRANT state.
REQ-016 arb_err  output  1  one-cycle pulse on timeout abort.
REQ-017 arb_err_cnt  output  8  saturating timeout count.

Function
REQ-018 The FSM SHALL have two states, IDLE and GRANT, plus a registered grant index g and a round-robin pointer last.
REQ-019 In IDLE, if any req_stb is high, the FSM SHALL select the first requester with req_stb high, searching from last+1 modulo NREQ, latch it into g, set last=g, and enter GRANT on the next edge.
REQ-020 In IDLE, if no req_stb is high, the FSM SHALL remain in IDLE, and xram_stb SHALL be 0.
REQ-021 In GRANT, the block SHALL drive the XRAM outputs combinationally: xram_stb=req_stb[g], xram_wr=req_wr[g], xram_addr=req_addr[g], xram_data_out=req_wdata[g].
REQ-022 req_ack[g] SHALL equal xram_ack in the same cycle while in GRANT; every other req_ack bit SHALL be 0.
REQ-023 req_rdata SHALL equal xram_data_in at all times.
REQ-024 On xram_ack in GRANT, the FSM SHALL return to IDLE, so there is at least one idle cycle between accesses, unless REQ-033 applies.
REQ-025 If req_stb[g] falls in GRANT without xram_ack, the FSM SHALL return to IDLE next cycle and SHALL issue no ack.
REQ-026 An 8-bit wait counter SHALL clear on entry to GRANT and increment on each GRANT cycle without xram_ack.
REQ-027 When the wait counter reaches TIMEOUT-1 without ack, the block SHALL:
- return to IDLE;
- pulse arb_err for one cycle;
- increment arb_err_cnt, saturating at 255.
REQ-028 An xram_ack that coincides with the timeout cycle SHALL win: the access completes normally and arb_err does not pulse.
REQ-029 xram_ack received in IDLE SHALL be ignored: no req_ack, no state change.
REQ-030 Latency from a request seen in IDLE to xram_stb is 1 cycle; worst-case grant wait for any requester is (NREQ-1)*(TIMEOUT+1) cycles.

Reset
REQ-031 While rst=0, the block SHALL hold: FSM=IDLE, g=0, last=NREQ-1 (so requester 0 wins first), wait counter=0, arb_err=0, arb_err_cnt=0.
REQ-032 During reset, arb_grant=0, arb_busy=0, xram_stb=0, xram_wr=0, and req_ack=0. Reset asserted mid-access SHALL abort the access immediately, with no ack and no error count.

Configuration
REQ-033 With macro XRAM_ARB_LOCK_EN defined: on xram_ack in GRANT with req_lock[g]=1 and req_stb[g]=1, the FSM SHALL stay in GRANT with the same g and clear the wait counter, giving back-to-back accesses. Without the macro, req_lock SHALL be ignored and REQ-024 always applies.

Verification
REQ-034 Reset, then req_stb=3'b111 held, with xram_ack one cycle after each xram_stb -> grants in order 0,1,2,0; req_ack pulses only on the granted bit.
REQ-035 Requester 1 reads addr 16'hf9f2, xram_data_in=8'h5a at ack -> xram_addr=16'hf9f2, xram_wr=0, req_rdata=8'h5a, req_ack=3'b010 for one cycle.
REQ-036 Requester 0 granted, xram_ack never asserted, TIMEOUT=64 -> return to IDLE on the 64th GRANT cycle, arb_err pulses once, arb_err_cnt=1; ack on exactly that cycle -> no error.
REQ-037 Requester 2 deasserts req_stb on the 2nd GRANT cycle -> xram_stb=0 that cycle, IDLE next cycle, no req_ack, arb_err_cnt unchanged.
REQ-038 XRAM_ARB_LOCK_EN defined, req_lock[0]=1, req_stb=3'b011 -> requester 0 completes 4 consecutive acks with no idle cycle before requester 1 is granted; macro undefined -> grants alternate 0,1.
REQ-039 rst driven low mid-GRANT -> xram_stb, arb_busy, and arb_grant go to 0 immediately; after release, requester 0 is granted first.
